// File: rtl/input_debounce4.sv
// -----------------------------------------------------------------------------
// input_debounce4
//
// Four-channel synchronizer and debouncer for raw switch/button levels.
// Each channel has a two-flop synchronizer followed by a small debounce FSM
// with a stability counter. A level change is accepted only after it has been
// seen on STABLE_CNT+1 consecutive synchronized samples. The debounced levels
// feed the downstream two-pair AND-OR combiner (bit 0 -> a, 1 -> b, 2 -> c,
// 3 -> d), so they come straight from registers with no combinational path
// from raw_in.
//
// Optional feature macro: DEBOUNCE_EDGE_EN
//   defined   : rise/fall one-cycle edge pulse registers are built.
//   undefined : rise/fall are tied to 4'b0000 (ports stay present).
//
// Parameters:
//   CNT_W      width of each per-channel stability counter
//   STABLE_CNT agreeing samples required after first detection
//              (legal: 2 <= STABLE_CNT <= 2**CNT_W - 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   raw_in     raw asynchronous inputs, one per channel
//   clean_out  debounced levels
//   rise       one-cycle pulse on clean_out[i] 0->1
//   fall       one-cycle pulse on clean_out[i] 1->0
//
// Debounce FSM states (per channel):
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   STABLE_LO | output low, synchronized input agrees
//   PEND_HI   | output low, input seen high, counting agreeing samples
//   STABLE_HI | output high, synchronized input agrees
//   PEND_LO   | output high, input seen low, counting agreeing samples
// -----------------------------------------------------------------------------
module input_debounce4 #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw_in,
  output logic [3:0] clean_out,
  output logic [3:0] rise,
  output logic [3:0] fall
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  // The counter starts at 0 on PEND entry, so reaching STABLE_CNT-1 while the
  // input still agrees means STABLE_CNT+1 agreeing samples including the one
  // that caused the PEND entry.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0] s1;
  logic [3:0] s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 4'b0000;
      s2 <= 4'b0000;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
        clean_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      case (state_q)
        STABLE_LO: begin
          if (s2[i]) begin
            state_d = PEND_HI;
            cnt_d   = '0;
          end
        end
        PEND_HI: begin
          if (!s2[i]) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (at_last) begin
            state_d = STABLE_HI;
            clean_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s2[i]) begin
            state_d = PEND_LO;
            cnt_d   = '0;
          end
        end
        PEND_LO: begin
          if (s2[i]) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (at_last) begin
            state_d = STABLE_LO;
            clean_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          clean_d = 1'b0;
        end
      endcase
    end

    assign clean_out[i] = clean_q;

`ifdef DEBOUNCE_EDGE_EN
    // clean_d only differs from clean_q on the edge that leaves a PEND state,
    // so registering the difference gives exactly one pulse per accepted edge,
    // aligned with the clean_out update. Rise and fall are mutually exclusive
    // by construction.
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= clean_d & ~clean_q;
        fall_q <= ~clean_d & clean_q;
      end
    end

    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
`else
    assign rise[i] = 1'b0;
    assign fall[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_input_debounce4.sv
// -----------------------------------------------------------------------------
// tb_input_debounce4
//
// Bench for input_debounce4 with STABLE_CNT=4, CNT_W=4. Expected outputs are
// queued with the edge number at which they must be visible; a monitor on the
// falling clock edge pops and compares them. Edge pulses are expected only
// when DEBOUNCE_EDGE_EN is defined for the build, otherwise rise/fall must
// stay zero.
// -----------------------------------------------------------------------------
module tb_input_debounce4;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] raw_in;
  logic [3:0] clean_out;
  logic [3:0] rise;
  logic [3:0] fall;

  input_debounce4 #(
    .CNT_W      (4),
    .STABLE_CNT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise      (rise),
    .fall      (fall)
  );

  typedef struct {
    int         cyc;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #20000;
    $display("FAIL watchdog: edge %0d reached, want run finished", edge_n);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int cyc, input logic [3:0] c, input logic [3:0] r,
                           input logic [3:0] f);
    exp_t e;
    e.cyc   = cyc;
    e.clean = c;
    e.rise  = EDGE_EN ? r : 4'b0000;
    e.fall  = EDGE_EN ? f : 4'b0000;
    sb_q.push_back(e);
  endtask

  // Position the driver at the falling edge that follows rising edge n.
  task automatic goto_neg(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    check_val($sformatf("rise_fall_excl@e%0d", edge_n), {28'd0, rise & fall}, 32'd0);
    while (sb_q.size() > 0 && sb_q[0].cyc <= edge_n) begin
      cur = sb_q.pop_front();
      if (cur.cyc < edge_n) begin
        check_val("stale_expectation", edge_n, cur.cyc);
      end else begin
        check_val($sformatf("clean@e%0d", edge_n), {28'd0, clean_out}, {28'd0, cur.clean});
        check_val($sformatf("rise@e%0d", edge_n),  {28'd0, rise},      {28'd0, cur.rise});
        check_val($sformatf("fall@e%0d", edge_n),  {28'd0, fall},      {28'd0, cur.fall});
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    raw_in = 4'b0000;
    expect_at(1, 4'h0, 4'h0, 4'h0);
    expect_at(2, 4'h0, 4'h0, 4'h0);
    expect_at(3, 4'h0, 4'h0, 4'h0);
    goto_neg(3);
    rst_n = 1'b1;

    // clean press on channel 0: change before edge 10, accepted at edge 16
    goto_neg(9);
    raw_in = 4'b0001;
    expect_at(10, 4'h0, 4'h0, 4'h0);
    expect_at(15, 4'h0, 4'h0, 4'h0);
    expect_at(16, 4'h1, 4'h1, 4'h0);
    expect_at(17, 4'h1, 4'h0, 4'h0);

    // glitch boundary on channel 1: 4-cycle pulse rejected
    goto_neg(20);
    raw_in = 4'b0011;
    goto_neg(24);
    raw_in = 4'b0001;
    expect_at(26, 4'h1, 4'h0, 4'h0);
    expect_at(27, 4'h1, 4'h0, 4'h0);
    expect_at(29, 4'h1, 4'h0, 4'h0);

    // 5-cycle pulse accepted at edge 39, its release accepted at edge 44
    goto_neg(32);
    raw_in = 4'b0011;
    goto_neg(37);
    raw_in = 4'b0001;
    expect_at(38, 4'h1, 4'h0, 4'h0);
    expect_at(39, 4'h3, 4'h2, 4'h0);
    expect_at(40, 4'h3, 4'h0, 4'h0);
    expect_at(43, 4'h3, 4'h0, 4'h0);
    expect_at(44, 4'h1, 4'h0, 4'h2);
    expect_at(45, 4'h1, 4'h0, 4'h0);

    // release on channel 2
    goto_neg(46);
    raw_in = 4'b0101;
    expect_at(52, 4'h1, 4'h0, 4'h0);
    expect_at(53, 4'h5, 4'h4, 4'h0);
    expect_at(54, 4'h5, 4'h0, 4'h0);
    goto_neg(55);
    raw_in = 4'b0001;
    expect_at(61, 4'h5, 4'h0, 4'h0);
    expect_at(62, 4'h1, 4'h0, 4'h4);
    expect_at(63, 4'h1, 4'h0, 4'h0);

    // bounce train on channel 3, final 0->1 before edge 75
    goto_neg(66);
    raw_in = 4'b1001;
    expect_at(71, 4'h1, 4'h0, 4'h0);
    expect_at(73, 4'h1, 4'h0, 4'h0);
    expect_at(75, 4'h1, 4'h0, 4'h0);
    goto_neg(68);
    raw_in = 4'b0001;
    goto_neg(70);
    raw_in = 4'b1001;
    goto_neg(72);
    raw_in = 4'b0001;
    goto_neg(74);
    raw_in = 4'b1001;
    expect_at(76, 4'h1, 4'h0, 4'h0);
    expect_at(78, 4'h1, 4'h0, 4'h0);
    expect_at(80, 4'h1, 4'h0, 4'h0);
    expect_at(81, 4'h9, 4'h8, 4'h0);
    expect_at(82, 4'h9, 4'h0, 4'h0);

    // return all low, then all four channels together
    goto_neg(85);
    raw_in = 4'b0000;
    expect_at(91, 4'h9, 4'h0, 4'h0);
    expect_at(92, 4'h0, 4'h0, 4'h9);
    expect_at(93, 4'h0, 4'h0, 4'h0);
    goto_neg(95);
    raw_in = 4'b1111;
    expect_at(101, 4'h0, 4'h0, 4'h0);
    expect_at(102, 4'hF, 4'hF, 4'h0);
    expect_at(103, 4'hF, 4'h0, 4'h0);
    goto_neg(105);
    raw_in = 4'b0000;
    expect_at(111, 4'hF, 4'h0, 4'h0);
    expect_at(112, 4'h0, 4'h0, 4'hF);
    expect_at(113, 4'h0, 4'h0, 4'h0);

    // reset mid-debounce: original acceptance at 122 is aborted by reset at
    // edge 120; raw high across release is accepted 6 edges after release
    goto_neg(115);
    raw_in = 4'b0001;
    expect_at(120, 4'h0, 4'h0, 4'h0);
    expect_at(122, 4'h0, 4'h0, 4'h0);
    expect_at(126, 4'h0, 4'h0, 4'h0);
    expect_at(127, 4'h1, 4'h1, 4'h0);
    expect_at(128, 4'h1, 4'h0, 4'h0);
    goto_neg(119);
    rst_n = 1'b0;
    goto_neg(120);
    rst_n = 1'b1;

    goto_neg(135);
    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
